fetch_pc_gen: RTL and testbench
===============================

# fetch_pc_gen

Fetch-PC generator for the instruction-fetch stage. It owns the fetch PC register and drives `ifPC`/`ifVld` both to the i-cache and to `branch_unit`. Each cycle it chooses the next PC from three sources: the execute-stage redirect, the same-cycle prediction from `branch_unit` (`pdPC`/`pdBranch`/`pdKnown`), or the sequential pair address. It also keeps every i-cache request stable until the cache accepts it, deferring a redirect if one arrives mid-request.

## Interface
- `ADDR_WIDTH`, 32, PC width.
- `RESET_PC`, 32'h1c000000, first fetch address after reset.
- `clk`  in  1  clock; the block uses this single clock domain.
- `rstn`  in  1  asynchronous, active-low reset.
- `pdPC`  in  ADDR_WIDTH  predicted target for the current `ifPC` (combinational from `branch_unit`).
- `pdBranch`  in  1  the prediction says taken.
- `pdKnown`  in  1  the prediction is valid this cycle.
- `exVld`  in  1  the execute-stage signals are valid.
- `exWrong`  in  1  the execute stage found a misprediction.
- `exPCTar`  in  ADDR_WIDTH  correct next PC after the mispredicted instruction.
- `icReady`  in  1  the i-cache accepts the current request this cycle.
- `fqFull`  in  1  the fetch queue is full; do not start a new request.
- `ifPC`  out  ADDR_WIDTH  fetch PC (registered).
- `ifVld`  out  1  a fetch request is valid; it also drives `branch_unit.ifVld`.
- `ifKill`  out  1  one-cycle flush: discard all fetch data accepted before this cycle.

## Operation
- Terms:
  - redirect = `exVld & exWrong`.
  - fire = `ifVld & icReady`.
  - seq = `{ifPC[ADDR_WIDTH-1:3] + 1, 3'b000}`; the PC advances by one 8-byte pair from the aligned base, so a PC with bit 2 set steps +4.
- All targets loaded into `ifPC` have bits [1:0] forced to 0.
- States:
  - BOOT: the single cycle after reset release.
  - FETCH: normal operation.
  - PEND: a redirect is waiting for the held request to be accepted.
- Held request: register `held` is set when `ifVld & ~icReady`. It is cleared on fire, and on reset.
- `ifVld` = (state != BOOT) & (~fqFull | held).
  - Once raised, `ifVld` stays high with `ifPC` unchanged until fire, even if `fqFull` rises.
- BOOT → FETCH unconditionally.
  - A redirect during BOOT loads `exPCTar` and sets `ifKill` next cycle.
- In FETCH, next `ifPC` is chosen by priority:
  1. Redirect and ~`held`: `ifPC` ← `exPCTar`. Any request firing this cycle is stale.
  2. Redirect and `held`: latch `exPCTar` into `pendPC`, go to PEND, keep `ifPC`.
  3. Fire, no redirect: `ifPC` ← (`pdKnown & pdBranch`) ? `pdPC` : seq.
  4. Otherwise: hold `ifPC`.
- In PEND:
  - A new redirect overwrites `pendPC` (the latest one wins).
  - On fire: `ifPC` ← `pendPC` (or the same-cycle `exPCTar` if a redirect is also present), then go to FETCH.
  - `ifVld` stays high in PEND only while `held`.
- `ifKill` is registered. It is 1 for exactly one cycle: the first cycle `ifPC` shows a redirect target (cases 1, PEND exit, BOOT redirect). Otherwise it is 0.
- Sequential wrap-around: seq of `32'hFFFF_FFF8` = `32'h0000_0000`. No overflow flag.
- Reset, asynchronous and valid at any time, including mid-request or in PEND:
  - `ifPC` = `RESET_PC`, `ifVld` = 0, `ifKill` = 0.
  - `held` = 0, `pendPC` = 0, state = BOOT.

## Timing
- Redirect-to-fetch latency with no held request: 1 cycle. `ifPC` = target and `ifKill` = 1 in cycle t+1.
- Redirect with a held request: `ifPC` = target in the cycle after the fire; `ifKill` rises in that same cycle.
- Prediction path: the taken target appears on `ifPC` 1 cycle after fire. Back-to-back fires give one request per cycle.
- `fqFull` gates only new requests. Deasserting it raises `ifVld` combinationally in the same cycle.
- `pd*` are sampled only on a fire cycle. They are ignored when `pdKnown` = 0.

## Test plan
- Reset with `RESET_PC` = 0x1c000000, `icReady` = 1, `fqFull` = 0:
  - `ifVld` = 0 in BOOT, then `ifPC` runs 0x1c000000, 0x1c000008, 0x1c000010, … one per cycle.
  - `ifKill` stays 0.
- Fire at `ifPC` = 0x1c000010 with `pdKnown` = 1, `pdBranch` = 1, `pdPC` = 0x1c000203:
  - next `ifPC` = 0x1c000200.
  - With `pdKnown` = 0 instead, next `ifPC` = 0x1c000018.
- Redirect at an idle point (`exPCTar` = 0x1c000400, `fqFull` = 1, no held request):
  - next cycle `ifPC` = 0x1c000400, `ifKill` = 1 for one cycle.
  - `ifVld` stays 0 until `fqFull` drops.
- Hold `icReady` = 0 for 3 cycles at `ifPC` = 0x1c000020. Redirect to 0x1c000500 in cycle 1, then to 0x1c000600 in cycle 2:
  - `ifPC` is stable through the hold.
  - After the fire, `ifPC` = 0x1c000600 with `ifKill` = 1.
- Wrap and alignment:
  - `ifPC` = 0xFFFFFFFC fires with no prediction: next `ifPC` = 0x00000000.
  - `ifPC` = 0x1c000004 fires: next `ifPC` = 0x1c000008.
- Assert `rstn` = 0 while in PEND:
  - all outputs return to reset values immediately.
  - after release, fetch restarts at `RESET_PC` with no `ifKill`.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC register with redirect, prediction and held-request handling
module fetch_pc_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h1c000000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] pdPC,
  input  logic                  pdBranch,
  input  logic                  pdKnown,
  input  logic                  exVld,
  input  logic                  exWrong,
  input  logic [ADDR_WIDTH-1:0] exPCTar,
  input  logic                  icReady,
  input  logic                  fqFull,
  output logic [ADDR_WIDTH-1:0] ifPC,
  output logic                  ifVld,
  output logic                  ifKill
);
  typedef enum logic [1:0] {BOOT, FETCH, PEND} state_t;
  localparam logic [ADDR_WIDTH-4:0] PAIR_STEP = 1;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pend_q, pend_d, seq, tar, pd_tar;
  logic held_q, held_d, kill_q, kill_d, redirect, fire, pd_taken;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      held_q  <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      held_q  <= held_d;
      kill_q  <= kill_d;
    end
  end
  always_comb begin
    ifVld  = (state_q != BOOT) & (~fqFull | held_q);
    ifPC   = pc_q;
    ifKill = kill_q;
  end
  // a redirect that lands on a held request is parked in pend until the cache accepts it
  always_comb begin
    redirect = exVld & exWrong;
    fire     = ifVld & icReady;
    pd_taken = pdKnown & pdBranch;
    seq      = {pc_q[ADDR_WIDTH-1:3] + PAIR_STEP, 3'b000};
    tar      = {exPCTar[ADDR_WIDTH-1:2], 2'b00};
    pd_tar   = {pdPC[ADDR_WIDTH-1:2], 2'b00};
    held_d   = ifVld & ~icReady;
    state_d  = state_q == BOOT ? FETCH
             : state_q == PEND ? (fire ? FETCH : PEND)
             : (redirect & held_q ? PEND : FETCH);
    pend_d   = redirect & (state_q == PEND | (state_q == FETCH & held_q)) ? tar : pend_q;
    kill_d   = state_q == BOOT ? redirect
             : state_q == PEND ? fire
             : redirect & ~held_q;
    pc_d     = state_q == BOOT ? (redirect ? tar : pc_q)
             : state_q == PEND ? (fire ? (redirect ? tar : pend_q) : pc_q)
             : redirect ? (held_q ? pc_q : tar)
             : fire ? (pd_taken ? pd_tar : seq) : pc_q;
  end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: randomized scoreboard bench for fetch_pc_gen against a behavioural model
module tb_fetch_pc_gen;
  localparam logic [31:0] RST_PC = 32'h1c000000;
  logic clk = 1'b0, rstn = 1'b0;
  logic [31:0] pdPC = '0, exPCTar = '0, ifPC;
  logic pdBranch = 0, pdKnown = 0, exVld = 0, exWrong = 0, icReady = 0, fqFull = 0;
  logic ifVld, ifKill;
  typedef struct {logic [31:0] pc; logic vld; logic kill;} exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  logic [31:0] m_pc, m_pend;
  bit m_boot, m_wait, m_hold, m_kill;

  fetch_pc_gen dut (
    .clk(clk), .rstn(rstn), .pdPC(pdPC), .pdBranch(pdBranch), .pdKnown(pdKnown),
    .exVld(exVld), .exWrong(exWrong), .exPCTar(exPCTar), .icReady(icReady),
    .fqFull(fqFull), .ifPC(ifPC), .ifVld(ifVld), .ifKill(ifKill)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = RST_PC; m_pend = 0; m_boot = 1; m_wait = 0; m_hold = 0; m_kill = 0;
  endtask

  // one cycle: drive inputs, queue the expected outputs, then advance the model over the coming edge
  task automatic step(input bit r, input bit ev, input bit ew, input logic [31:0] tar,
                      input bit icr, input bit fq, input bit pk, input bit pb, input logic [31:0] pp);
    exp_t e;
    bit redir, vld, fire;
    logic [31:0] t;
    @(negedge clk);
    rstn = ~r; exVld = ev; exWrong = ew; exPCTar = tar; icReady = icr; fqFull = fq;
    pdKnown = pk; pdBranch = pb; pdPC = pp;
    if (r) model_reset();
    #1;
    redir = ev && ew;
    vld = !m_boot && (!fq || m_hold);
    fire = vld && icr;
    e.pc = m_pc; e.vld = vld; e.kill = m_kill;
    exp_q.push_back(e);
    if (!r) begin
      t = tar & 32'hFFFF_FFFC;
      m_kill = 0;
      if (m_boot) begin
        m_boot = 0;
        if (redir) begin m_pc = t; m_kill = 1; end
      end else if (m_wait) begin
        if (fire) begin m_pc = redir ? t : m_pend; m_kill = 1; m_wait = 0; end
        else if (redir) m_pend = t;
      end else if (redir && !m_hold) begin
        m_pc = t; m_kill = 1;
      end else if (redir) begin
        m_pend = t; m_wait = 1;
      end else if (fire) begin
        m_pc = (pk && pb) ? (pp & 32'hFFFF_FFFC) : (m_pc & 32'hFFFF_FFF8) + 32'd8;
      end
      m_hold = vld && !icr;
    end
  endtask

  task automatic idle(input bit icr, input bit fq);
    step(0, 0, 0, 0, icr, fq, 0, 0, 0);
  endtask

  task automatic redirect_to(input logic [31:0] tar, input bit icr, input bit fq);
    step(0, 1, 1, tar, icr, fq, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (ifPC !== e.pc || ifVld !== e.vld || ifKill !== e.kill) begin
          errors++;
          $display("FAIL outputs t=%0t: got pc=%h vld=%b kill=%b, expected pc=%h vld=%b kill=%b",
                   $time, ifPC, ifVld, ifKill, e.pc, e.vld, e.kill);
        end
      end
    end
  end

  initial begin : stimulus
    model_reset();
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    repeat (4) idle(1, 0);
    step(0, 0, 0, 0, 1, 0, 1, 1, 32'h1c000203);
    idle(1, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1, 32'h1c000303);
    idle(1, 1);
    redirect_to(32'h1c000400, 1, 1);
    repeat (2) idle(1, 1);
    idle(1, 0);
    redirect_to(32'h1c000020, 1, 0);
    idle(0, 0);
    redirect_to(32'h1c000500, 0, 1);
    redirect_to(32'h1c000600, 0, 1);
    idle(1, 1);
    idle(1, 0);
    redirect_to(32'hFFFF_FFFC, 1, 0);
    idle(1, 0);
    idle(1, 0);
    redirect_to(32'h1c000004, 1, 0);
    idle(1, 0);
    idle(1, 0);
    idle(0, 0);
    redirect_to(32'h1c000700, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    repeat (4) idle(1, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
           $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
    end
    @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
